// File: rtl/rtc_time_reader.sv
//------------------------------------------------------------------------------
// Module : rtc_time_reader
// Brief  : Bus initiator that latches an RTC time snapshot and reads it back.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rtc_time_reader #(
  parameter int POLL_GAP = 4,
  parameter int POLL_MAX = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_in,
  output logic        wr_out,
  output logic        rd_out,
  output logic [7:0]  addr_out,
  output logic [31:0] data_out,
  input  logic [31:0] data_in,
  output logic        busy_out,
  output logic        done_out,
  output logic        err_out,
  output logic [47:0] time_sec_out,
  output logic [37:0] time_ns_out
);

  localparam logic [3:0] C_GAP_LAST = 4'(POLL_GAP - 1);
  localparam logic [9:0] C_POLL_MAX = 10'(POLL_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_SET, S_GAP, S_POLL, S_CHK, S_RD, S_CAP_UNUSED, S_FIN, S_ERR
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_gap_cnt;
  logic [9:0]  r_poll_cnt;
  logic [1:0]  r_rd_idx;
  logic        r_cap_vld;
  logic [1:0]  r_cap_idx;
  logic [47:0] r_sh_sec;
  logic [29:0] r_sh_ns_hi;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    wr_out   = 1'b0;
    rd_out   = 1'b0;
    addr_out = 8'h00;
    data_out = 32'h0;
    busy_out = 1'b1;
    done_out = 1'b0;
    err_out  = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) w_next = S_CLR;
      end
      S_CLR: begin
        wr_out = 1'b1;
        w_next = S_SET;
      end
      S_SET: begin
        wr_out   = 1'b1;
        data_out = 32'h1;
        w_next   = S_GAP;
      end
      S_GAP: if (r_gap_cnt == C_GAP_LAST) w_next = S_POLL;
      S_POLL: begin
        rd_out = 1'b1;
        w_next = S_CHK;
      end
      // Status word from the POLL read is on data_in this cycle
      S_CHK: begin
        if (data_in[0])                     w_next = S_RD;
        else if (r_poll_cnt < C_POLL_MAX)   w_next = S_GAP;
        else                                w_next = S_ERR;
      end
      S_RD: begin
        rd_out   = 1'b1;
        addr_out = {4'h1, r_rd_idx, 2'b00};
        if (r_rd_idx == 2'd3) w_next = S_FIN;
      end
      S_FIN: begin
        wr_out   = 1'b1;
        done_out = 1'b1;
        w_next   = S_IDLE;
      end
      S_ERR: begin
        wr_out  = 1'b1;
        err_out = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gap_cnt    <= 4'd0;
      r_poll_cnt   <= 10'd0;
      r_rd_idx     <= 2'd0;
      r_cap_vld    <= 1'b0;
      r_cap_idx    <= 2'd0;
      r_sh_sec     <= 48'h0;
      r_sh_ns_hi   <= 30'h0;
      time_sec_out <= 48'h0;
      time_ns_out  <= 38'h0;
    end else begin
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 4'd1 : 4'd0;
      r_rd_idx  <= (r_state == S_RD)  ? r_rd_idx + 2'd1  : 2'd0;
      r_cap_vld <= (r_state == S_RD);
      r_cap_idx <= r_rd_idx;
      if (r_state == S_SET)       r_poll_cnt <= 10'd0;
      else if (r_state == S_POLL) r_poll_cnt <= r_poll_cnt + 10'd1;
      // Read data lands one cycle after its strobe; the last word arrives in FIN
      if (r_cap_vld) begin
        case (r_cap_idx)
          2'd0:    r_sh_sec[47:32] <= data_in[15:0];
          2'd1:    r_sh_sec[31:0]  <= data_in;
          2'd2:    r_sh_ns_hi      <= data_in[29:0];
          default: ;
        endcase
      end
      if (r_state == S_FIN) begin
        time_sec_out <= r_sh_sec;
        time_ns_out  <= {r_sh_ns_hi, data_in[7:0]};
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/rtc_time_reader.md
RTC_TIME_READER -- requirements
Module: rtc_time_reader

Interface
REQ-001 Parameter POLL_GAP, default 4: idle clk cycles between status-poll reads and after the request write (legal 2..15).
REQ-002 Parameter POLL_MAX, default 1023: maximum status polls before timeout (legal 1..1023).
REQ-003 clk  in  1  single clock, all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start_in  in  1  one-cycle request to capture RTC time; ignored while busy_out=1.
REQ-006 wr_out  out  1  generic-bus write strobe, one cycle per write.
REQ-007 rd_out  out  1  generic-bus read strobe, one cycle per read.
REQ-008 addr_out  out  8  byte address; bits [1:0] always 0.
REQ-009 data_out  out  32  write data; valid when wr_out=1, otherwise 0.
REQ-010 data_in  in  32  read data; valid exactly one cycle after the rd_out cycle.
REQ-011 busy_out  out  1  high from start acceptance until done_out/err_out cycle inclusive.
REQ-012 done_out  out  1  one-cycle pulse: time_sec_out/time_ns_out updated.
REQ-013 err_out  out  1  one-cycle pulse: poll timeout, outputs not updated.
REQ-014 time_sec_out  out  48  captured seconds, held until next done_out.
REQ-015 time_ns_out  out  38  captured ns (30 bit ns, 8 bit fractional), held until next done_out.

Function
REQ-016 Block SHALL be the bus initiator for the register block: never assert wr_out and rd_out in the same cycle; at most one access per cycle.
REQ-017 States SHALL be IDLE, CLR, SET, GAP, POLL, CHK, RD, CAP, FIN, ERR.
REQ-018 IDLE: start_in=1 -> CLR next cycle, busy_out=1 from that cycle.
REQ-019 CLR: wr_out=1, addr 0x00, data 0x00000000 (drops any stale time_rd bit); -> SET.
REQ-020 SET: wr_out=1, addr 0x00, data 0x00000001 (rising time_rd edge); poll counter cleared; -> GAP.
REQ-021 GAP: count POLL_GAP cycles with no bus activity; -> POLL.
REQ-022 POLL: rd_out=1, addr 0x00, poll counter +1; -> CHK.
REQ-023 CHK: sample data_in[0] (time_ok); 1 -> RD; 0 and poll counter<POLL_MAX -> GAP; 0 and counter=POLL_MAX -> ERR.
REQ-024 RD: four consecutive cycles, rd_out=1, addr 0x10, 0x14, 0x18, 0x1C.
REQ-025 Capture SHALL be pipelined one cycle behind RD: sec[47:32]=data_in[15:0] of 0x10, sec[31:0]=data_in of 0x14, ns[37:8]=data_in[29:0] of 0x18, ns[7:0]=data_in[7:0] of 0x1C; unused bits ignored.
REQ-026 Captures SHALL go to shadow registers; time_sec_out/time_ns_out update together only in FIN.
REQ-027 FIN (cycle after last capture): wr_out=1, addr 0x00, data 0x00000000; outputs updated; done_out=1; -> IDLE.
REQ-028 ERR: wr_out=1, addr 0x00, data 0x00000000; err_out=1; outputs unchanged; -> IDLE.
REQ-029 Nominal latency, start_in at cycle 0, time_ok=1 on first poll: CLR 1, SET 2, GAP 3..2+POLL_GAP, POLL 3+POLL_GAP, CHK 4+POLL_GAP, RD 5+POLL_GAP..8+POLL_GAP, FIN 9+POLL_GAP (cycle 13 at default).
REQ-030 Each extra failed poll SHALL add POLL_GAP+2 cycles.
REQ-031 start_in while busy_out=1, including the done_out/err_out cycle, SHALL be dropped, not queued.
REQ-032 done_out and err_out SHALL never both be 1.

Reset
REQ-033 rst=1 SHALL force, asynchronously: state IDLE, wr_out/rd_out/done_out/err_out/busy_out=0, addr_out=0x00, data_out=0, time_sec_out=0, time_ns_out=0, counters 0.
REQ-034 rst mid-sequence SHALL abort with no further bus strobes; first accepted start after release restarts at CLR.

Verification
REQ-035 Register-block model, time sec=0x0000_1234_5678_9ABC, ns field 0x3B9AC9FF_A5 (38 bit), time_ok=1 on first poll -> done_out at cycle 13, time_sec_out=0x123456789ABC, time_ns_out matches, bus trace CLR,SET,POLL,4 reads,clear-write.
REQ-036 time_ok returns 1 on 3rd poll -> exactly 3 reads of 0x00, done_out at cycle 25 (default POLL_GAP).
REQ-037 POLL_MAX=3, time_ok stuck 0 -> 3 polls, err_out pulse, final write 0x00=0, time outputs keep previous values.
REQ-038 start_in pulsed every cycle for 40 cycles -> exactly 2 sequences executed, no overlapping strobes, wr_out&rd_out never 1 together.
REQ-039 rst asserted during RD state (2nd read) -> all strobes 0 same cycle, outputs 0; new start completes normally.
REQ-040 Unused data_in bits (0x10[31:16], 0x18[31:30], 0x1C[31:8]) driven 1 -> captured values unaffected.
